// File: rtl/sha256_dispatcher.sv
// Round-robin job dispatcher feeding a pool of SHA-256 cores, with per-core
// result buffers drained through one registered valid/ready result channel.
module sha256_dispatcher #(
    parameter int N_REQ   = 4,
    parameter int N_CORES = 4
) (
    input  logic                   aclk,
    input  logic                   areset,
    input  logic                   enable,
    input  logic [N_REQ-1:0]       req_valid,
    output logic [N_REQ-1:0]       req_ready,
    input  logic [N_REQ*448-1:0]   req_words,
    input  logic [N_REQ*8-1:0]     req_size,
    output logic [N_CORES*448-1:0] core_words,
    output logic [N_CORES*8-1:0]   core_size,
    output logic [N_CORES-1:0]     core_string_dv,
    input  logic [N_CORES-1:0]     core_string_ready,
    input  logic [N_CORES-1:0]     core_sha256_dv,
    input  logic [N_CORES*256-1:0] core_sha256_data,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [255:0]           res_data,
    output logic [2:0]             res_req_id,
    output logic [2:0]             res_core_id,
    output logic [3:0]             busy_count,
    output logic                   err_spurious
);

    localparam int unsigned NR = N_REQ;
    localparam int unsigned NC = N_CORES;

    logic [NC-1:0]      busy_q, busy_d;
    logic [NC-1:0]      rb_valid_q, rb_valid_d;
    logic [NC-1:0]      dv_q, dv_d;
    logic [2:0]         owner_q [NC];
    logic [2:0]         owner_d [NC];
    logic [2:0]         rb_req_q [NC];
    logic [2:0]         rb_req_d [NC];
    logic [255:0]       rb_data_q [NC];
    logic [255:0]       rb_data_d [NC];
    logic [NC*448-1:0]  words_q, words_d;
    logic [NC*8-1:0]    size_q, size_d;
    logic [2:0]         rr_req_q, rr_req_d;
    logic [2:0]         rr_core_q, rr_core_d;
    logic               res_valid_q, res_valid_d;
    logic [255:0]       res_data_q, res_data_d;
    logic [2:0]         res_req_id_q, res_req_id_d;
    logic [2:0]         res_core_id_q, res_core_id_d;
    logic [3:0]         busy_count_q, busy_count_d;
    logic               err_spurious_q, err_spurious_d;

    logic [NC-1:0]      free;
    logic               core_found, req_found, fire, rb_found;
    logic [2:0]         gc, gr, rc;
    logic [3:0]         idx;
    logic [3:0]         cidx;

    // Grant selection: lowest free core, first valid requester from rr_req.
    always_comb begin
        free       = core_string_ready & ~busy_q & ~rb_valid_q;
        core_found = 1'b0;
        gc         = '0;
        for (int unsigned k = 0; k < NC; k++) begin
            if (!core_found && free[k]) begin
                core_found = 1'b1;
                gc         = 3'(k);
            end
        end
        req_found = 1'b0;
        gr        = '0;
        idx       = '0;
        for (int unsigned i = 0; i < NR; i++) begin
            idx = 4'(rr_req_q) + 4'(i);
            if (idx >= 4'(NR)) idx = idx - 4'(NR);
            if (!req_found && req_valid[idx]) begin
                req_found = 1'b1;
                gr        = idx[2:0];
            end
        end
        fire      = enable & ~areset & core_found & req_found;
        req_ready = '0;
        if (fire) req_ready[gr] = 1'b1;
    end

    always_comb begin
        busy_d         = busy_q;
        rb_valid_d     = rb_valid_q;
        owner_d        = owner_q;
        rb_req_d       = rb_req_q;
        rb_data_d      = rb_data_q;
        words_d        = words_q;
        size_d         = size_q;
        dv_d           = '0;
        rr_req_d       = rr_req_q;
        rr_core_d      = rr_core_q;
        res_valid_d    = res_valid_q;
        res_data_d     = res_data_q;
        res_req_id_d   = res_req_id_q;
        res_core_id_d  = res_core_id_q;
        err_spurious_d = err_spurious_q;
        rb_found       = 1'b0;
        rc             = '0;
        cidx           = '0;

        for (int unsigned k = 0; k < NC; k++) begin
            if (core_sha256_dv[k]) begin
                if (busy_q[k]) begin
                    rb_valid_d[k] = 1'b1;
                    rb_data_d[k]  = core_sha256_data[k*256 +: 256];
                    rb_req_d[k]   = owner_q[k];
                    busy_d[k]     = 1'b0;
                end else begin
                    err_spurious_d = 1'b1;
                end
            end
        end

        if (fire) begin
            words_d[int'(gc)*448 +: 448] = req_words[int'(gr)*448 +: 448];
            size_d[int'(gc)*8 +: 8]      = req_size[int'(gr)*8 +: 8];
            owner_d[gc]                  = gr;
            busy_d[gc]                   = 1'b1;
            dv_d[gc]                     = 1'b1;
            rr_req_d = (int'(gr) == N_REQ - 1) ? 3'd0 : gr + 3'd1;
        end

        // Drain uses registered rb_valid; a capture never lands on a buffered core.
        if (!res_valid_q || res_ready) begin
            for (int unsigned i = 0; i < NC; i++) begin
                cidx = 4'(rr_core_q) + 4'(i);
                if (cidx >= 4'(NC)) cidx = cidx - 4'(NC);
                if (!rb_found && rb_valid_q[cidx]) begin
                    rb_found = 1'b1;
                    rc       = cidx[2:0];
                end
            end
            res_valid_d = rb_found;
            if (rb_found) begin
                res_data_d    = rb_data_q[rc];
                res_req_id_d  = rb_req_q[rc];
                res_core_id_d = rc;
                rb_valid_d[rc] = 1'b0;
                rr_core_d = (int'(rc) == N_CORES - 1) ? 3'd0 : rc + 3'd1;
            end
        end

        busy_count_d = '0;
        for (int unsigned k = 0; k < NC; k++) begin
            busy_count_d = busy_count_d + 4'(busy_d[k]);
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            busy_q         <= '0;
            rb_valid_q     <= '0;
            dv_q           <= '0;
            words_q        <= '0;
            size_q         <= '0;
            rr_req_q       <= '0;
            rr_core_q      <= '0;
            res_valid_q    <= 1'b0;
            res_data_q     <= '0;
            res_req_id_q   <= '0;
            res_core_id_q  <= '0;
            busy_count_q   <= '0;
            err_spurious_q <= 1'b0;
            for (int unsigned k = 0; k < NC; k++) begin
                owner_q[k]   <= '0;
                rb_req_q[k]  <= '0;
                rb_data_q[k] <= '0;
            end
        end else begin
            busy_q         <= busy_d;
            rb_valid_q     <= rb_valid_d;
            dv_q           <= dv_d;
            words_q        <= words_d;
            size_q         <= size_d;
            rr_req_q       <= rr_req_d;
            rr_core_q      <= rr_core_d;
            res_valid_q    <= res_valid_d;
            res_data_q     <= res_data_d;
            res_req_id_q   <= res_req_id_d;
            res_core_id_q  <= res_core_id_d;
            busy_count_q   <= busy_count_d;
            err_spurious_q <= err_spurious_d;
            owner_q        <= owner_d;
            rb_req_q       <= rb_req_d;
            rb_data_q      <= rb_data_d;
        end
    end

    assign core_words     = words_q;
    assign core_size      = size_q;
    assign core_string_dv = dv_q;
    assign res_valid      = res_valid_q;
    assign res_data       = res_data_q;
    assign res_req_id     = res_req_id_q;
    assign res_core_id    = res_core_id_q;
    assign busy_count     = busy_count_q;
    assign err_spurious   = err_spurious_q;

endmodule

// File: doc/sha256_dispatcher.md
# sha256_dispatcher

Job scheduler that shares a pool of `sha256_core_pif` hash cores among several independent requesters. Each requester submits one pre-padded 14-word message block plus its byte size. The dispatcher grants requesters round-robin, loads the block into a free core and holds it there, then captures each core's one-cycle digest pulse into a per-core result buffer. Buffered digests are returned through a single valid/ready result channel, tagged with requester and core IDs. It sits between host or search-manager logic and the core array, in place of direct per-core wiring.

## Interface
- `N_REQ`, 4: number of requesters (2..8).
- `N_CORES`, 4: number of attached cores (1..8).
- `aclk` in 1: single clock.
- `areset` in 1: synchronous, active-high reset.
- `enable` in 1: dispatch enable. Low blocks new grants only.
- `req_valid` in N_REQ: per-requester job valid.
- `req_ready` out N_REQ: per-requester accept. At most one bit high per cycle.
- `req_words` in N_REQ*448: 14 words per requester. Word n of requester r is at `[r*448+n*32 +: 32]`.
- `req_size` in N_REQ*8: message size in bytes, per requester.
- `core_words` out N_CORES*448: registered block per core, same packing as `req_words`.
- `core_size` out N_CORES*8: registered size per core.
- `core_string_dv` out N_CORES: one-cycle load strobe per core.
- `core_string_ready` in N_CORES: core idle indication.
- `core_sha256_dv` in N_CORES: one-cycle digest strobe.
- `core_sha256_data` in N_CORES*256: digests, 256 bits per core.
- `res_valid` out 1: result valid.
- `res_ready` in 1: result accept.
- `res_data` out 256: digest.
- `res_req_id` out 3: originating requester.
- `res_core_id` out 3: core that computed the digest.
- `busy_count` out 4: number of cores currently busy.
- `err_spurious` out 1: sticky flag. Set when a core pulses `core_sha256_dv` while not busy.

## Operation
- **Per-core state.** Each core has:
  - `busy` flag;
  - `owner` (requester ID);
  - result buffer: `rb_valid`, `rb_data`, `rb_req`.
- **Free core.** A core is free when `core_string_ready & ~busy & ~rb_valid`, evaluated on registered state only.
- **Grant.** When `enable` is high and at least one core is free:
  - the round-robin pointer selects the first requester with `req_valid` high, starting at `rr_req`;
  - the free core with the lowest index is the target;
  - `req_ready[r]` is driven combinationally for that requester only.
- **Accept.** A handshake (`req_valid[r] & req_ready[r]`) on core k does the following at the clock edge:
  - `core_words[k]` and `core_size[k]` load from requester r;
  - `owner[k] = r`, `busy[k] = 1`;
  - `rr_req` moves to r+1, wrapping modulo N_REQ;
  - `core_string_dv[k]` is high for exactly the next cycle.
- **Hold.** `core_words[k]` and `core_size[k]` stay stable until `busy[k]` clears.
- **Capture.** `core_sha256_dv[k]` while `busy[k]` sets `rb_valid[k]`, latches the data and `owner[k]`, and clears `busy[k]`.
- **Spurious digest.** `core_sha256_dv[k]` with `busy[k]` low: data is discarded and `err_spurious` is set. Only reset clears it.
- **Output stage.** This is a registered holding stage.
  - When `~res_valid | res_ready`, the first `rb_valid` core at or after `rr_core` is loaded into `res_*`.
  - That core's `rb_valid` clears and `rr_core` advances past it.
  - If no buffer is valid, `res_valid` drops.
  - `res_*` stay stable while `res_valid & ~res_ready`.
- **`busy_count`.** Registered popcount of `busy`.
- **`enable` low.** In-flight jobs complete and results still drain; no grants are made.

## Timing
- **Reset.** Every output and internal register goes to 0: `req_ready`, `core_words`, `core_size`, `core_string_dv`, `res_*`, `busy_count`, `err_spurious`, `busy`, `rb_valid`, and both round-robin pointers.
  - Reset mid-operation drops all in-flight jobs and buffered results. No `res_valid` is produced for them.
  - Cores are reset from the same signal (`aresetn = ~areset` at the top level).
- **Accept to strobe.** Accept at edge T gives `core_string_dv` high during cycle T+1 only.
- **Digest to result.** Digest pulse in cycle C gives `rb_valid` in C+1 and earliest `res_valid` in C+2.
- **Throughput.** At most one grant per cycle and one result per cycle.
- **Core reuse.** A core becomes free the cycle after its buffer is drained. A grant never targets a core in the same cycle its buffer is read.
- **Simultaneous events.**
  - A capture on one core and a drain on another in the same cycle are independent.
  - A capture and a grant never hit the same core in the same cycle, because a grant requires `~busy`.
- **All cores busy or buffered.** `req_ready` is all zero. Requesters must hold `req_valid` and their data until accepted.

## Test plan
1. **Single job.** Requester 0 submits "abc": w0=0x61626380, w1..w13=0, size=3. Behavioural core with 10-cycle latency.
   - Required: `core_string_dv[0]` for one cycle.
   - Required: `res_data` = 0xba7816bf…f20015ad, `res_req_id`=0, `res_core_id`=0.
   - Required: `busy_count` goes 1 then 0.
2. **Contention.** Four requesters valid at once, `rr_req`=0.
   - Required: grants to requesters 0,1,2,3 on consecutive cycles, mapped to cores 0,1,2,3.
   - Required: 4 results, each tagged with the correct requester.
3. **Oversubscription.** Six jobs with N_CORES=4.
   - Required: jobs 5 and 6 are accepted only after a core's result is drained.
   - Required: no job is lost or duplicated; 6 results.
4. **Backpressure.** `res_ready`=0 for 50 cycles while 4 digests complete.
   - Required: `res_*` held stable, no grants, `busy_count`=0.
   - Required: after release, 4 results on consecutive cycles in round-robin core order.
5. **Reset mid-operation.** Assert `areset` for 1 cycle with 3 jobs in flight.
   - Required: all outputs return to 0 and no stale `res_valid` appears.
   - Required: a new job afterwards completes normally.
6. **Spurious digest.** Pulse `core_sha256_dv[2]` while core 2 is idle.
   - Required: `err_spurious`=1, no `res_valid`, and no effect on other jobs.
